// File: rtl/line_draw_engine.sv
// rtl/line_draw_engine.sv - Bresenham line rasteriser with a valid/ready pixel stream
// Optional build macro LINE_CLIP_EN: suppress pixels outside H_RES x V_RES.
module line_draw_engine #(
  parameter int CW    = 12,
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [CW-1:0] x0,
  input  logic signed [CW-1:0] y0,
  input  logic signed [CW-1:0] x1,
  input  logic signed [CW-1:0] y1,
  output logic                 busy,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 done
);

  localparam int DW = CW + 2;
  localparam logic signed [DW-1:0] ONE = DW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DW-1:0] r_x, r_y, r_x1, r_y1;
  logic signed [DW-1:0] r_dx, r_dy, r_err;
  logic                 r_sx_neg, r_sy_neg;

  logic signed [DW-1:0] w_ddx, w_ddy, w_adx, w_ndy;
  logic signed [DW:0]   w_e2, w_dx_ext, w_dy_ext;
  logic                 w_step_x, w_step_y;
  logic signed [DW-1:0] w_err_nxt;
  logic                 w_last, w_onscreen, w_adv;

  // Setup arithmetic: deltas and step directions from the latched endpoints
  always_comb begin
    w_ddx = r_x1 - r_x;
    w_ddy = r_y1 - r_y;
    w_adx = w_ddx[DW-1] ? -w_ddx : w_ddx;
    w_ndy = w_ddy[DW-1] ? w_ddy : -w_ddy;
  end

  // Bresenham step decision; e2 carries one extra bit so 2*err cannot overflow
  always_comb begin
    w_e2      = {r_err, 1'b0};
    w_dx_ext  = {r_dx[DW-1], r_dx};
    w_dy_ext  = {r_dy[DW-1], r_dy};
    w_step_x  = (w_e2 >= w_dy_ext);
    w_step_y  = (w_e2 <= w_dx_ext);
    w_err_nxt = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);
    w_last    = (r_x == r_x1) && (r_y == r_y1);
  end

  // Visibility of the current pixel; off-screen pixels are skipped without a handshake
  always_comb begin
`ifdef LINE_CLIP_EN
    w_onscreen = !r_x[DW-1] && (r_x < DW'(H_RES)) &&
                 !r_y[DW-1] && (r_y < DW'(V_RES));
`else
    w_onscreen = 1'b1;
`endif
    w_adv = (r_state == S_DRAW) && (w_onscreen ? pix_ready : 1'b1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SETUP;
      S_SETUP: w_next = S_DRAW;
      S_DRAW:  if (w_adv && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; busy drops as soon as the done pulse is shown
  always_comb begin
    busy      = (r_state == S_SETUP) || (r_state == S_DRAW);
    pix_valid = (r_state == S_DRAW) && w_onscreen;
    done      = (r_state == S_DONE);
  end

  // Datapath: latch endpoints, run setup, then step the current point per advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_x  <= DW'(x0);
          r_y  <= DW'(y0);
          r_x1 <= DW'(x1);
          r_y1 <= DW'(y1);
        end
        S_SETUP: begin
          r_dx     <= w_adx;
          r_dy     <= w_ndy;
          r_err    <= w_adx + w_ndy;
          r_sx_neg <= w_ddx[DW-1];
          r_sy_neg <= w_ddy[DW-1];
        end
        S_DRAW: if (w_adv && !w_last) begin
          r_err <= w_err_nxt;
          if (w_step_x) r_x <= r_sx_neg ? r_x - ONE : r_x + ONE;
          if (w_step_y) r_y <= r_sy_neg ? r_y - ONE : r_y + ONE;
        end
        default: ;
      endcase
    end
  end

  assign pix_x = r_x[XW-1:0];
  assign pix_y = r_y[YW-1:0];

endmodule
